aes_round_sched: RTL and testbench
==================================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NR, default 10, the round count; legal values are 10, 12 and 14.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a new block (plaintext and key) is presented to the datapath.
REQ-005 SHALL have port in_ready, output, 1 bit: the scheduler accepts a block.
REQ-006 SHALL have port out_valid, output, 1 bit: the datapath state register holds the finished ciphertext.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-008 SHALL have port flush, input, 1 bit: synchronous abort of the block in flight.
REQ-009 SHALL have port dp_init, output, 1 bit: the datapath loads state = plaintext XOR key and loads the key register.
REQ-010 SHALL have port dp_en, output, 1 bit: the datapath state and round-key registers update this cycle.
REQ-011 SHALL have port dp_round, output, 4 bits: the current round number, 1..NR.
REQ-012 SHALL have port dp_last, output, 1 bit: final round; the datapath bypasses MixColumns.
REQ-013 SHALL have port dp_rcon, output, 8 bits: the key-expansion round constant for dp_round.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, INIT, ROUND, FINAL and DONE.
REQ-016 SHALL assert in_ready in IDLE, and in DONE only while out_ready=1; it is deasserted in all other states.
REQ-017 SHALL take IDLE->INIT when in_valid & in_ready; on any other cycle IDLE holds.
REQ-018 SHALL, in INIT, drive dp_init=1 and dp_en=1 for one cycle, then go to ROUND with round counter=1.
REQ-019 SHALL, in ROUND, drive dp_en=1 and dp_round=counter, then increment the counter; ROUND->FINAL once counter reaches NR-1.
REQ-020 SHALL, in FINAL, drive dp_en=1, dp_last=1 and dp_round=NR for one cycle, then go to DONE.
REQ-021 SHALL, in DONE, hold out_valid=1 with dp_en=0 until out_ready=1.
REQ-022 SHALL, when DONE sees out_ready=1, go to INIT if in_valid=1 (back-to-back, no IDLE bubble), else to IDLE.
REQ-023 SHALL give a latency of NR+2 cycles from input handshake edge to first out_valid edge (12 for NR=10).
REQ-024 SHALL map dp_rcon for rounds 1..10 to 01,02,04,08,10,20,40,80,1b,36 and drive 00 for rounds above 10.
REQ-025 SHALL drive dp_rcon=00 and dp_round=0 outside ROUND/FINAL.
REQ-026 SHALL drive dp_en=0 and dp_init=0 in IDLE and DONE.
REQ-027 SHALL make out_valid, in_ready, busy and dp_* registered or purely state-decoded; no combinational path from in_valid to any output.
REQ-028 SHALL, on flush=1 in any state, enter IDLE next cycle with out_valid=0; flush overrides a simultaneous input or output handshake, and that block is neither accepted nor delivered.
REQ-029 SHALL ignore in_valid while busy and not in DONE; the producer holds it.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, counter=0, out_valid=0, busy=0, dp_*=0, in_ready=0.
REQ-031 SHALL assert in_ready on the first cycle after rst deasserts.
REQ-032 SHALL discard the block in flight when reset asserts mid-operation; no out_valid follows.

Configuration
REQ-033 SHALL, with AES_BLK_CNT_EN defined, add output blk_cnt[15:0]: reset to 0, +1 per output handshake, wraps FFFF->0000, unchanged by flush.
REQ-034 SHALL, without AES_BLK_CNT_EN, have no blk_cnt port and no counter logic.

Structure
REQ-035 SHALL place the FSM state enum, the RCON table and the NR default in package aes_pkg.
REQ-036 SHALL implement the round-number->rcon lookup as sub-module aes_rcon_rom (combinational, 4-bit in, 8-bit out).

Verification
REQ-037 SHALL verify a single block at NR=10: in_valid pulse at cycle 0 -> dp_init at cycle 1, dp_round 1..9 at cycles 2..10, dp_last at cycle 11 with rcon 36, out_valid at cycle 12.
REQ-038 SHALL verify back-to-back operation: in_valid held and out_ready=1 -> second dp_init on the cycle after the first DONE, zero idle cycles.
REQ-039 SHALL verify backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held, dp_en=0, in_ready=0 throughout.
REQ-040 SHALL verify flush: flush at round 5 with in_valid=1 -> IDLE next cycle, no out_valid, the new block is not accepted that cycle.
REQ-041 SHALL verify reset mid-operation: rst=0 during round 3 -> all outputs 0 immediately, in_ready=1 after release.
REQ-042 SHALL verify the counter with AES_BLK_CNT_EN: 3 delivered blocks plus 1 flushed block -> blk_cnt=3.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the AES round scheduler.
//   NR_DEFAULT   : default round count (AES-128)
//   aes_state_e  : scheduler FSM state encoding
//   RCON_TABLE   : key-expansion round constants indexed by round number;
//                  entry 0 and entries 11..15 are zero so any 4-bit round
//                  number can index the table directly.
package aes_pkg;

    localparam int NR_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } aes_state_e;

    localparam logic [7:0] RCON_TABLE [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_rcon_rom.sv
// aes_rcon_rom -- combinational round-number to round-constant lookup.
//   round : input, 4 bits, round number (0 and 11..15 give 00)
//   rcon  : output, 8 bits, key-expansion round constant
module aes_rcon_rom
    import aes_pkg::*;
(
    input  logic [3:0] round,
    output logic [7:0] rcon
);

    assign rcon = RCON_TABLE[round];

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched -- control FSM sequencing an iterative AES datapath.
//
// Optional feature: define AES_BLK_CNT_EN to add the blk_cnt output, a
// 16-bit wrapping count of delivered ciphertext blocks.
//
// Ports:
//   clk        : input,  clock, rising edge
//   rst        : input,  asynchronous active-low reset
//   in_valid   : input,  producer presents plaintext+key
//   in_ready   : output, scheduler accepts a block
//   out_valid  : output, datapath state register holds the ciphertext
//   out_ready  : input,  consumer takes the ciphertext
//   flush      : input,  synchronous abort of the block in flight
//   dp_init    : output, datapath loads state = pt ^ key and the key reg
//   dp_en      : output, datapath state / round-key registers update
//   dp_round   : output, 4 bits, current round number (0 when not in a round)
//   dp_last    : output, final round, MixColumns bypassed
//   dp_rcon    : output, 8 bits, round constant for dp_round
//   busy       : output, high in every state except IDLE
//   dbg_state  : output, 3 bits, raw FSM state for observation
//   blk_cnt    : output, 16 bits, delivered block count (AES_BLK_CNT_EN only)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high and flush is low; the producer holds valid (and its data)
// until that edge. in_valid is ignored while a block is in flight, except
// in DONE where it selects a back-to-back restart.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       flush,
    output logic       dp_init,
    output logic       dp_en,
    output logic [3:0] dp_round,
    output logic       dp_last,
    output logic [7:0] dp_rcon,
    output logic       busy,
    output logic [2:0] dbg_state
`ifdef AES_BLK_CNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    localparam logic [3:0] LAST_MID = 4'(NR - 1);  // last non-final round
    localparam logic [3:0] NR_ROUND = 4'(NR);

    aes_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                state_d = ST_ROUND;
                cnt_d   = 4'd1;
            end
            ST_ROUND: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_MID) begin
                    state_d = ST_FINAL;
                    cnt_d   = 4'd0;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Back-to-back restart skips IDLE entirely.
                if (out_ready) state_d = in_valid ? ST_INIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Flush wins over both handshakes: the block is dropped.
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode state only; in_ready also looks at out_ready and is
    // held low while reset is applied even though the state reads IDLE.
    assign in_ready  = rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dp_init   = (state_q == ST_INIT);
    assign dp_en     = (state_q == ST_INIT) | (state_q == ST_ROUND) | (state_q == ST_FINAL);
    assign dp_last   = (state_q == ST_FINAL);
    assign dp_round  = (state_q == ST_ROUND) ? cnt_q :
                       (state_q == ST_FINAL) ? NR_ROUND : 4'd0;
    assign dbg_state = state_q;

    aes_rcon_rom u_rcon_rom (
        .round (dp_round),
        .rcon  (dp_rcon)
    );

`ifdef AES_BLK_CNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic        deliver;

    assign deliver = (state_q == ST_DONE) & out_ready & ~flush;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (deliver) blk_cnt_d = blk_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blk_cnt_q <= 16'd0;
        else      blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched -- self-checking bench for aes_round_sched (NR = 10).
// Optional feature covered when AES_BLK_CNT_EN is defined.
module tb_aes_round_sched;

    localparam int NR = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, out_ready, flush;
    logic       in_ready, out_valid, dp_init, dp_en, dp_last, busy;
    logic [3:0] dp_round;
    logic [7:0] dp_rcon;
    logic [2:0] dbg_state;
`ifdef AES_BLK_CNT_EN
    logic [15:0] blk_cnt;
`endif

    aes_round_sched #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .dp_init   (dp_init),
        .dp_en     (dp_en),
        .dp_round  (dp_round),
        .dp_last   (dp_last),
        .dp_rcon   (dp_rcon),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef AES_BLK_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    // ---------------- check bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Round constant by repeated GF(2^8) doubling, zero outside rounds 1..10.
    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] v;
        if (r < 1 || r > 10) return 8'h00;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        return v;
    endfunction

    // A block in flight is described by its age in cycles since INIT:
    // age 0 = init, 1..NR-1 = rounds, NR = final, > NR = waiting to deliver.
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_cnt  = 16'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_cnt  = 16'd0;
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age <= NR) begin
            m_age++;
        end else if (out_ready) begin
            m_cnt++;
            if (in_valid) m_age = 0;
            else          m_busy = 1'b0;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        bit done;
        int rnd;
        done = m_busy && (m_age > NR);
        rnd  = (m_busy && m_age >= 1 && m_age <= NR) ? m_age : 0;
        chk1("in_ready",  in_ready,  rst && (!m_busy || (done && out_ready)));
        chk1("out_valid", out_valid, done);
        chk1("busy",      busy,      m_busy);
        chk1("dp_init",   dp_init,   m_busy && m_age == 0);
        chk1("dp_en",     dp_en,     m_busy && m_age <= NR);
        chk1("dp_last",   dp_last,   m_busy && m_age == NR);
        chkw("dp_round",  32'(dp_round), 32'(rnd));
        chkw("dp_rcon",   32'(dp_rcon),  32'(rcon_of(rnd)));
`ifdef AES_BLK_CNT_EN
        chkw("blk_cnt",   32'(blk_cnt),  32'(m_cnt));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk1(name, busy, 1'b0);
    endtask

    task automatic wait_out_valid(input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk1(name, out_valid, 1'b1);
    endtask

    task automatic wait_round(input string name, input logic [3:0] r);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dp_round == r) break;
        end
        chkw(name, 32'(dp_round), 32'(r));
    endtask

    task automatic run_block();
        after_edge();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        after_edge();
        in_valid  = 1'b0;
        wait_out_valid("block_delivered");
        after_edge();
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int init_c, last_c, ov_c, init2_c;
    logic [7:0] last_rcon;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        // Reset state and release.
        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        after_edge();
        rst = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Single block, cycle 0 = handshake cycle; out_ready low for backpressure.
        after_edge();
        in_valid = 1'b1;
        @(negedge clk);
        chk1("c0_in_ready", in_ready, 1'b1);
        after_edge();
        in_valid = 1'b0;
        init_c = -1; last_c = -1; ov_c = -1; last_rcon = 8'h00;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (dp_init && init_c < 0) init_c = c;
            if (c == 5)  chkw("round4_at_c5", 32'(dp_round), 32'd4);
            if (c == 10) chkw("rcon_r9_is_1b", 32'(dp_rcon), 32'h1b);
            if (dp_last && last_c < 0) begin
                last_c    = c;
                last_rcon = dp_rcon;
            end
            if (out_valid) begin
                ov_c = c;
                break;
            end
        end
        chkw("init_cycle", 32'(init_c), 32'd1);
        chkw("last_cycle", 32'(last_c), 32'd11);
        chkw("last_rcon",  32'(last_rcon), 32'h36);
        chkw("out_valid_cycle", 32'(ov_c), 32'd12);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk1("bp_dp_en", dp_en, 1'b0);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        after_edge();
        out_ready = 1'b1;
        @(negedge clk);
        chk1("done_in_ready", in_ready, 1'b1);
        after_edge();
        out_ready = 1'b0;
        @(negedge clk);
        chk1("idle_after_deliver", busy, 1'b0);

        // Back-to-back: in_valid held, out_ready high.
        after_edge();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        init_c = -1; ov_c = -1; init2_c = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dp_init) begin
                if (init_c < 0) init_c = c;
                else begin
                    init2_c = c;
                    break;
                end
            end
            if (out_valid && ov_c < 0) ov_c = c;
        end
        after_edge();
        in_valid = 1'b0;
        chkw("b2b_init1", 32'(init_c), 32'd1);
        chkw("b2b_done1", 32'(ov_c), 32'd12);
        chkw("b2b_init2", 32'(init2_c), 32'd13);
        wait_idle("b2b_idle");
        after_edge();
        out_ready = 1'b0;

        // Flush at round 5 with in_valid high.
        after_edge();
        in_valid = 1'b1;
        after_edge();
        in_valid = 1'b0;
        wait_round("reach_round4", 4'd4);
        after_edge();
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chkw("flush_round5", 32'(dp_round), 32'd5);
        after_edge();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_no_init", dp_init, 1'b0);
        repeat (15) begin
            @(negedge clk);
            chk1("flush_no_out_valid", out_valid, 1'b0);
        end

        // Flush in IDLE rejects a simultaneous input handshake.
        after_edge();
        flush    = 1'b1;
        in_valid = 1'b1;
        after_edge();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk1("idle_flush_rejects", busy, 1'b0);

        // Reset during round 3.
        after_edge();
        in_valid = 1'b1;
        after_edge();
        in_valid = 1'b0;
        wait_round("reach_round2", 4'd2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_dp_en", dp_en, 1'b0);
        chkw("mid_rst_dp_round", 32'(dp_round), 32'd0);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        after_edge();
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_release_in_ready", in_ready, 1'b1);
        repeat (15) begin
            @(negedge clk);
            chk1("rst_no_out_valid", out_valid, 1'b0);
        end

        // Three delivered blocks, then one flushed while offered in DONE.
        run_block();
        run_block();
        run_block();
        after_edge();
        in_valid = 1'b1;
        after_edge();
        in_valid = 1'b0;
        wait_out_valid("flush_blk_reach_done");
        after_edge();
        flush     = 1'b1;
        out_ready = 1'b1;
        after_edge();
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk1("done_flush_out_valid", out_valid, 1'b0);
`ifdef AES_BLK_CNT_EN
        chkw("blk_cnt_final", 32'(blk_cnt), 32'd3);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
